muldiv_arbiter: RTL and testbench

- Shares the single iterative multiply/divide unit between the two issue lanes of the superscalar core.
- Lane 0 always holds the older instruction.
- The block accepts one M-extension request, latches its operands, pulses the unit's start, and waits for the unit's done.
- It then returns the result to the owning lane through a valid/ready response port, and handles pipeline flush while the unit is mid-operation.

---
 rtl/muldiv_arbiter.sv | 157 +++++++++++++++
 tb/tb_muldiv_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_arbiter.sv
// Arbitrates the two issue lanes onto one iterative mul/div unit, with flush
// draining and a hung-unit timeout.
module muldiv_arbiter #(
  parameter int XLEN    = 32,
  parameter int OPW     = 6,
  parameter int TAGW    = 4,
  parameter int TIMEOUT = 80
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  input  logic [OPW-1:0]  req0_alucode,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [TAGW-1:0] req0_tag,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [OPW-1:0]  req1_alucode,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [TAGW-1:0] req1_tag,
  output logic            req1_ready,
  output logic            unit_start,
  output logic [OPW-1:0]  unit_alucode,
  output logic [XLEN-1:0] unit_a,
  output logic [XLEN-1:0] unit_b,
  input  logic            unit_done,
  input  logic [XLEN-1:0] unit_result,
  input  logic            flush,
  output logic            rsp_valid,
  output logic            rsp_lane,
  output logic [TAGW-1:0] rsp_tag,
  output logic [XLEN-1:0] rsp_data,
  input  logic            rsp_ready,
  output logic            busy,
  output logic            timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_RESP, S_DRAIN} state_t;

  state_t          r_state;
  logic [OPW-1:0]  r_op;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [TAGW-1:0] r_tag;
  logic            r_lane;
  logic [CW-1:0]   r_cnt;
  logic            r_unit_start;
  logic            r_rsp_valid;
  logic [XLEN-1:0] r_rsp_data;
  logic            r_timeout_err;

  logic w_can_accept;
  logic w_accept0;
  logic w_accept1;
  logic w_cnt_last;

  assign w_can_accept = (r_state == S_IDLE) && !flush && !reset;
  assign req0_ready   = w_can_accept;
  assign req1_ready   = w_can_accept && !req0_valid;
  assign w_accept0    = req0_valid && req0_ready;
  assign w_accept1    = req1_valid && req1_ready;
  assign w_cnt_last   = (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_op          <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_tag         <= '0;
      r_lane        <= 1'b0;
      r_cnt         <= '0;
      r_unit_start  <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_unit_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept0) begin
            r_op         <= req0_alucode;
            r_a          <= req0_a;
            r_b          <= req0_b;
            r_tag        <= req0_tag;
            r_lane       <= 1'b0;
            r_unit_start <= 1'b1;
            r_state      <= S_START;
          end else if (w_accept1) begin
            r_op         <= req1_alucode;
            r_a          <= req1_a;
            r_b          <= req1_b;
            r_tag        <= req1_tag;
            r_lane       <= 1'b1;
            r_unit_start <= 1'b1;
            r_state      <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= flush ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          // A done coinciding with flush has nothing left to drain.
          if (flush) begin
            r_cnt   <= '0;
            r_state <= unit_done ? S_IDLE : S_DRAIN;
          end else if (unit_done) begin
            r_rsp_data  <= unit_result;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (w_cnt_last) begin
            r_timeout_err <= 1'b1;
            r_rsp_data    <= '0;
            r_rsp_valid   <= 1'b1;
            r_state       <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RESP: begin
          if (flush || rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (unit_done) begin
            r_state <= S_IDLE;
          end else if (w_cnt_last) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The unit re-samples its operands, so the latches drive it continuously.
  assign unit_start   = r_unit_start;
  assign unit_alucode = r_op;
  assign unit_a       = r_a;
  assign unit_b       = r_b;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_lane     = r_lane;
  assign rsp_tag      = r_tag;
  assign rsp_data     = r_rsp_data;
  assign busy         = (r_state != S_IDLE);
  assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Scoreboard bench for muldiv_arbiter: directed requests, a behavioural
// mul/div unit, and a monitor that checks every response handshake.
module tb_muldiv_arbiter;
  localparam int XLEN = 32;
  localparam int OPW = 6;
  localparam int TAGW = 4;
  localparam int TIMEOUT = 80;
  localparam logic [OPW-1:0] OP_MUL = 6'd0;
  localparam logic [OPW-1:0] OP_DIVU = 6'd5;

  logic clk = 1'b0;
  logic reset;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [OPW-1:0] req0_alucode, req1_alucode, unit_alucode;
  logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b, unit_a, unit_b;
  logic [TAGW-1:0] req0_tag, req1_tag, rsp_tag;
  logic unit_start, unit_done, flush, rsp_valid, rsp_lane, rsp_ready, busy, timeout_err;
  logic [XLEN-1:0] unit_result, rsp_data;

  typedef struct packed {
    logic            lane;
    logic [TAGW-1:0] tag;
    logic [XLEN-1:0] data;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int hs_cyc = -1;
  int m_lat = 8;
  bit m_hang = 1'b0;
  logic [XLEN-1:0] m_res;

  muldiv_arbiter #(.XLEN(XLEN), .OPW(OPW), .TAGW(TAGW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_alucode(req0_alucode), .req0_a(req0_a),
    .req0_b(req0_b), .req0_tag(req0_tag), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_alucode(req1_alucode), .req1_a(req1_a),
    .req1_b(req1_b), .req1_tag(req1_tag), .req1_ready(req1_ready),
    .unit_start(unit_start), .unit_alucode(unit_alucode), .unit_a(unit_a),
    .unit_b(unit_b), .unit_done(unit_done), .unit_result(unit_result),
    .flush(flush), .rsp_valid(rsp_valid), .rsp_lane(rsp_lane), .rsp_tag(rsp_tag),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural unit: done pulses m_lat cycles after start, unless hung.
  initial begin
    unit_done = 1'b0;
    unit_result = '0;
    forever begin
      @(negedge clk);
      if (unit_start && !m_hang) begin
        m_res = (unit_alucode == OP_DIVU) ? unit_a / unit_b : unit_a * unit_b;
        repeat (m_lat) @(posedge clk);
        #1;
        unit_done = 1'b1;
        unit_result = m_res;
        @(posedge clk);
        #1;
        unit_done = 1'b0;
        unit_result = '0;
      end
    end
  end

  // Monitor: pops the scoreboard on every rsp handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && rsp_valid) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("[TB] FAIL unexpected_rsp: rsp_valid=1 data %0h, expected no response", rsp_data);
        end else if (rsp_ready) begin
          e = sb.pop_front();
          $display("[TB] rsp lane %0d tag %0h data %0h (cycle %0d)", rsp_lane, rsp_tag, rsp_data, cyc);
          check("rsp_lane", 32'(rsp_lane), 32'(e.lane));
          check("rsp_tag", 32'(rsp_tag), 32'(e.tag));
          check("rsp_data", rsp_data, e.data);
          hs_cyc = cyc;
        end
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("[TB] FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
    $fatal(1, "watchdog");
  end

  // Starts at posedge+1, returns at posedge+1 just after the accepting edge.
  task automatic issue(input bit lane, input logic [OPW-1:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [TAGW-1:0] tag,
                       input logic [XLEN-1:0] exp_data, input bit push, output int t_acc);
    bit got;
    got = 1'b0;
    t_acc = -1;
    if (lane == 1'b0) begin
      req0_alucode = op; req0_a = a; req0_b = b; req0_tag = tag; req0_valid = 1'b1;
    end else begin
      req1_alucode = op; req1_a = a; req1_b = b; req1_tag = tag; req1_valid = 1'b1;
    end
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if ((lane == 1'b0 && req0_ready) || (lane == 1'b1 && req1_ready)) begin
        got = 1'b1;
        t_acc = cyc;
        if (push) sb.push_back('{lane, tag, exp_data});
        $display("[TB] req lane %0d op %0d a %0h b %0h tag %0h accepted (cycle %0d)", lane, op, a, b, tag, cyc);
      end
      @(posedge clk);
      #1;
    end
    if (lane == 1'b0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
    check("accept", 32'(got), 32'd1);
  endtask

  task automatic wait_valid(input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1'b1;
    end
    check("rsp_valid_arrives", 32'(ok), 32'd1);
  endtask

  task automatic wait_empty(input int bound);
    for (int i = 0; i < bound && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int t0, t1;
    reset = 1'b1; flush = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_alucode = '0; req0_a = '0; req0_b = '0; req0_tag = '0;
    req1_valid = 1'b0; req1_alucode = '0; req1_a = '0; req1_b = '0; req1_tag = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_unit_start", 32'(unit_start), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_req0_ready", 32'(req0_ready), 32'd1);
    check("rst_req1_ready", 32'(req1_ready), 32'd1);

    // Flush in IDLE blocks acceptance
    @(posedge clk); #1 flush = 1'b1; req0_valid = 1'b1;
    @(negedge clk);
    check("flush_idle_req0_ready", 32'(req0_ready), 32'd0);
    check("flush_idle_req1_ready", 32'(req1_ready), 32'd0);
    @(posedge clk); #1 flush = 1'b0; req0_valid = 1'b0;
    @(negedge clk);
    check("flush_idle_no_accept", 32'(busy), 32'd0);

    // Lane 0 MUL 7*6, latency 8
    @(posedge clk); #1 m_lat = 8;
    issue(1'b0, OP_MUL, 32'd7, 32'd6, 4'h5, 32'd42, 1'b1, t0);
    @(negedge clk);
    check("t1_unit_start", 32'(unit_start), 32'd1);
    check("t1_start_cycle", 32'(cyc), 32'(t0 + 1));
    check("t1_unit_a", unit_a, 32'd7);
    check("t1_unit_b", unit_b, 32'd6);
    check("t1_unit_op", 32'(unit_alucode), 32'(OP_MUL));
    @(negedge clk);
    check("t1_start_one_cycle", 32'(unit_start), 32'd0);
    repeat (3) @(negedge clk);
    check("t1_unit_a_held", unit_a, 32'd7);
    check("t1_busy_wait", 32'(busy), 32'd1);
    wait_valid(40);
    check("t1_rsp_latency", 32'(cyc), 32'(t0 + 10));
    wait_empty(20);

    // Simultaneous requests: lane 0 first, lane 1 right after handshake
    @(posedge clk); #1 m_lat = 3;
    req1_alucode = OP_MUL; req1_a = 32'd3; req1_b = 32'd5; req1_tag = 4'h9; req1_valid = 1'b1;
    req0_alucode = OP_MUL; req0_a = 32'd3; req0_b = 32'd4; req0_tag = 4'h1; req0_valid = 1'b1;
    @(negedge clk);
    check("prio_req0_ready", 32'(req0_ready), 32'd1);
    check("prio_req1_ready", 32'(req1_ready), 32'd0);
    sb.push_back('{1'b0, 4'h1, 32'd12});
    @(posedge clk); #1 req0_valid = 1'b0;
    issue(1'b1, OP_MUL, 32'd3, 32'd5, 4'h9, 32'd15, 1'b1, t1);
    check("prio_lane1_after_hs", 32'(t1), 32'(hs_cyc + 1));
    wait_empty(40);

    // rsp_ready held low 5 cycles; lane 1 waits
    @(posedge clk); #1 m_lat = 4; rsp_ready = 1'b0;
    issue(1'b0, OP_MUL, 32'd9, 32'd9, 4'h3, 32'd81, 1'b1, t0);
    req1_alucode = OP_MUL; req1_a = 32'd2; req1_b = 32'd8; req1_tag = 4'hC; req1_valid = 1'b1;
    wait_valid(40);
    for (int i = 0; i < 5; i++) begin
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_rsp_data", rsp_data, 32'd81);
      check("stall_rsp_tag", 32'(rsp_tag), 32'h3);
      check("stall_req1_ready", 32'(req1_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    issue(1'b1, OP_MUL, 32'd2, 32'd8, 4'hC, 32'd16, 1'b1, t1);
    wait_empty(40);

    // Flush 3 cycles into WAIT for DIVU 100/7
    @(posedge clk); #1 m_lat = 8;
    issue(1'b0, OP_DIVU, 32'd100, 32'd7, 4'h6, 32'd14, 1'b0, t0);
    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("drain_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    check("drain_idle_cycle", 32'(cyc), 32'(t0 + 10));
    check("drain_no_rsp", 32'(rsp_valid), 32'd0);

    // Hung unit -> timeout with zero data
    @(posedge clk); #1 m_hang = 1'b1;
    check("pre_timeout_err", 32'(timeout_err), 32'd0);
    issue(1'b1, OP_MUL, 32'd11, 32'd11, 4'hA, 32'd0, 1'b1, t1);
    wait_valid(TIMEOUT + 20);
    check("timeout_err_set", 32'(timeout_err), 32'd1);
    wait_empty(10);
    m_hang = 1'b0;
    repeat (5) @(negedge clk);
    check("timeout_err_sticky", 32'(timeout_err), 32'd1);

    // Reset during WAIT; late done ignored
    @(posedge clk); #1 m_lat = 20;
    issue(1'b0, OP_MUL, 32'd2, 32'd3, 4'h7, 32'd6, 1'b0, t0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_unit_start", 32'(unit_start), 32'd0);
    check("mid_rst_unit_a", unit_a, 32'd0);
    check("mid_rst_unit_b", unit_b, 32'd0);
    check("mid_rst_unit_op", 32'(unit_alucode), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_rsp_tag", 32'(rsp_tag), 32'd0);
    check("mid_rst_rsp_lane", 32'(rsp_lane), 32'd0);
    check("mid_rst_rsp_data", rsp_data, 32'd0);
    check("mid_rst_timeout_err", 32'(timeout_err), 32'd0);
    repeat (25) @(negedge clk);
    check("late_done_busy", 32'(busy), 32'd0);
    check("late_done_rsp_valid", 32'(rsp_valid), 32'd0);
    check("final_scoreboard", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
